demux4_12: RTL and testbench

// - 1-to-4 stream demultiplexer for 12-bit words; the distributing counterpart of the 4:1 12-bit mux.
// - Accepts one word per cycle on a valid/ready input and steers it by s[1:0] to one of four output channels.
// - Each channel has its own small FIFO, so a stalled consumer blocks only its own channel.
// - Sits between a single producer and four independent consumers in the datapath.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_chan_fifo.sv | 107 ++++++++++
 rtl/demux4_12.sv | 83 ++++++++
 tb/tb_demux4_12.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 12-bit stream demultiplexer.
package demux_pkg;

    localparam int unsigned NCH      = 4;
    localparam int unsigned DefWidth = 12;
    localparam int unsigned DefDepth = 2;

    typedef logic [1:0] sel_t;

    // Per-channel FIFO fill state; PARTIAL covers every occupancy strictly between 0 and DEPTH.
    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StPartial = 2'd1,
        StFull    = 2'd2
    } chan_state_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel of the demux: a small circular FIFO with an EMPTY/PARTIAL/FULL tracker.
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             do_push, do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Fill-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill-state transitions; push and pop together leave the state unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (do_push) state_d = StPartial;
            end
            StPartial: begin
                if (do_push && !do_pop && occ_q == OccW'(DEPTH - 1)) begin
                    state_d = StFull;
                end else if (do_pop && !do_push && occ_q == OccW'(1)) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (do_pop) state_d = StPartial;
            end
            default: state_d = StEmpty;
        endcase
    end

    // Status and head-of-queue outputs.
    always_comb begin
        full  = (state_q == StFull);
        empty = (state_q == StEmpty);
        occ   = occ_q;
        rdata = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/demux4_12.sv
// 1-to-4 stream demultiplexer: steers each accepted word by s into a per-channel FIFO.
module demux4_12
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    input  sel_t                   s,
    input  logic                   d_valid,
    output logic                   d_ready,
    output logic [WIDTH-1:0]       y0,
    output logic [WIDTH-1:0]       y1,
    output logic [WIDTH-1:0]       y2,
    output logic [WIDTH-1:0]       y3,
    output logic [NCH-1:0]         y_valid,
    input  logic [NCH-1:0]         y_ready,
    output logic [$clog2(DEPTH):0] occ0,
    output logic [$clog2(DEPTH):0] occ1,
    output logic [$clog2(DEPTH):0] occ2,
    output logic [$clog2(DEPTH):0] occ3
);

    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    logic [NCH-1:0]   push_oh;
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [WIDTH-1:0] rdata [NCH];
    logic [OccW-1:0]  occ   [NCH];

    // Ready depends on the selected channel's fullness only, never on y_ready.
    always_comb begin
        d_ready = ~full[s];
    end

    // One-hot push decode of the select.
    always_comb begin
        push_oh = '0;
        if (d_valid && d_ready) begin
            unique case (s)
                2'd0: push_oh = 4'b0001;
                2'd1: push_oh = 4'b0010;
                2'd2: push_oh = 4'b0100;
                2'd3: push_oh = 4'b1000;
                default: push_oh = '0;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_oh[k]),
            .wdata (d),
            .pop   (y_ready[k]),
            .rdata (rdata[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .occ   (occ[k])
        );
    end

    // Channel outputs; data is forced to zero while a channel holds nothing.
    always_comb begin
        y_valid = ~empty;
        y0      = empty[0] ? '0 : rdata[0];
        y1      = empty[1] ? '0 : rdata[1];
        y2      = empty[2] ? '0 : rdata[2];
        y3      = empty[3] ? '0 : rdata[3];
        occ0    = occ[0];
        occ1    = occ[1];
        occ2    = occ[2];
        occ3    = occ[3];
    end

endmodule

// File: tb/tb_demux4_12.sv
// Self-checking bench for demux4_12: directed scenarios plus random traffic vs a queue model.
module tb_demux4_12;

    localparam int unsigned W     = 12;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  d;
    logic [1:0]    s;
    logic          d_valid;
    logic          d_ready;
    logic [W-1:0]  y0, y1, y2, y3;
    logic [3:0]    y_valid;
    logic [3:0]    y_ready;
    logic [1:0]    occ0, occ1, occ2, occ3;

    logic [W-1:0]  yv [4];
    logic [1:0]    ov [4];

    int total = 0;
    int bad   = 0;

    // Reference: one queue of words per channel.
    logic [W-1:0]  mq [4][$];

    demux4_12 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .s       (s),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .occ0    (occ0),
        .occ1    (occ1),
        .occ2    (occ2),
        .occ3    (occ3)
    );

    always #5 clk = ~clk;

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign ov[0] = occ0;
    assign ov[1] = occ1;
    assign ov[2] = occ2;
    assign ov[3] = occ3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
        chk({ph, " d_ready"}, 32'(d_ready), 32'(mq[s].size() < DEPTH));
        chk({ph, " y_valid"}, 32'(y_valid), 32'(ev));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s y%0d", ph, k), 32'(yv[k]),
                32'(mq[k].size() != 0 ? mq[k][0] : '0));
            chk($sformatf("%s occ%0d", ph, k), 32'(ov[k]), 32'(mq[k].size()));
            chk($sformatf("%s occ%0d_range", ph, k), 32'(ov[k] <= DEPTH), 32'(1));
        end
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic cycle(input string ph, output bit acc);
        bit [3:0] pop;
        @(negedge clk);
        check_all(ph);
        acc = d_valid && (mq[s].size() < DEPTH);
        for (int k = 0; k < 4; k++) pop[k] = y_ready[k] && (mq[k].size() != 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pop[k]) void'(mq[k].pop_front());
        if (acc) mq[s].push_back(d);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] sel, input logic [W-1:0] w,
                         input logic [3:0] rdy);
        d_valid = v;
        s       = sel;
        d       = w;
        y_ready = rdy;
    endtask

    initial begin
        bit acc;
        bit held;
        logic [W-1:0] seq;

        rst_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'h0);
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Routing: one word to each channel, all consumers ready.
        drive(1'b1, 2'd0, 12'h0A5, 4'hF); cycle("route0", acc);
        drive(1'b1, 2'd1, 12'h15A, 4'hF); cycle("route1", acc);
        drive(1'b1, 2'd2, 12'h2F0, 4'hF); cycle("route2", acc);
        drive(1'b1, 2'd3, 12'h30F, 4'hF); cycle("route3", acc);
        drive(1'b0, 2'd0, '0, 4'hF);      cycle("route_tail", acc);
        cycle("route_idle", acc);

        // Backpressure on ch2; ch0 must still flow.
        drive(1'b1, 2'd2, 12'h111, 4'b1011); cycle("bp_a", acc);
        drive(1'b1, 2'd2, 12'h222, 4'b1011); cycle("bp_b", acc);
        drive(1'b1, 2'd2, 12'h444, 4'b1011); cycle("bp_full", acc);
        chk("bp_full_rejected", 32'(acc), 32'(0));
        drive(1'b1, 2'd0, 12'h333, 4'b1011); cycle("bp_ch0", acc);
        drive(1'b0, 2'd0, '0, 4'b1011);      cycle("bp_ch0_out", acc);
        drive(1'b0, 2'd0, '0, 4'hF);         cycle("bp_drain0", acc);
        cycle("bp_drain1", acc);
        cycle("bp_drain2", acc);

        // Full ch3 with simultaneous pop: the push must wait one cycle.
        drive(1'b1, 2'd3, 12'h001, 4'b0111); cycle("fp_a", acc);
        drive(1'b1, 2'd3, 12'h002, 4'b0111); cycle("fp_b", acc);
        drive(1'b1, 2'd3, 12'h003, 4'hF);    cycle("fp_stall", acc);
        chk("fp_stall_rejected", 32'(acc), 32'(0));
        cycle("fp_accept", acc);
        chk("fp_accept_taken", 32'(acc), 32'(1));
        drive(1'b0, 2'd0, '0, 4'hF);
        for (int i = 0; i < 3; i++) cycle("fp_drain", acc);

        // Streaming: 100 back-to-back words through ch1.
        for (int i = 0; i < 100; i++) begin
            seq = W'(12'h500 + i);
            drive(1'b1, 2'd1, seq, 4'hF);
            cycle("stream", acc);
            chk("stream_accept", 32'(acc), 32'(1));
        end
        drive(1'b0, 2'd0, '0, 4'hF);
        cycle("stream_tail", acc);
        cycle("stream_idle", acc);

        // Reset mid-stream with two words parked on ch1.
        drive(1'b1, 2'd1, 12'h7A1, 4'h0); cycle("rst_a", acc);
        drive(1'b1, 2'd1, 12'h7A2, 4'h0); cycle("rst_b", acc);
        drive(1'b0, 2'd1, '0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) mq[k].delete();
        chk("rst_async y_valid", 32'(y_valid), 32'(0));
        chk("rst_async occ1", 32'(occ1), 32'(0));
        chk("rst_async y1", 32'(y1), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("rst_release");
        cycle("rst_idle", acc);

        // Random traffic; the producer holds a rejected word until it is accepted.
        held = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!held) begin
                d_valid = ($urandom_range(0, 3) != 0);
                s       = 2'($urandom_range(0, 3));
                d       = W'($urandom);
            end
            y_ready = 4'($urandom);
            cycle("rand", acc);
            held = d_valid && !acc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
